// File: rtl/brick_hit_queue.sv
// Turns per-pixel bullet/brick overlap hits into de-duplicated grid-cell collision events
// and presents them one at a time as a pulse train with guaranteed low gaps.
module brick_hit_queue #(
    parameter int BLOCK_SHIFT = 5,
    parameter int COLS        = 17,
    parameter int ROWS        = 14,
    parameter int DEPTH       = 4,
    parameter int HOLD_CYCLES = 2,
    parameter int GAP_CYCLES  = 2
) (
    input  logic                         clk,
    input  logic                         resetN,
    input  logic [10:0]                  pixelX,
    input  logic [10:0]                  pixelY,
    input  logic [10:0]                  topLeftX,
    input  logic [10:0]                  topLeftY,
    input  logic                         hitRequest,
    input  logic                         startOfFrame,
    output logic [4:0]                   brickCollisionX,
    output logic [3:0]                   brickCollisionY,
    output logic                         collision,
    output logic                         overflow,
    output logic [$clog2(DEPTH+1)-1:0]   queueCount,
    output logic [1:0]                   dbg_state_o
);

    localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW   = $clog2(DEPTH + 1);
    localparam int MAXC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int TW   = (MAXC > 1) ? $clog2(MAXC) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ASSERT, S_GAP} state_t;

    // Input stage: pixel -> cell, out-of-grid hits filtered before dedup
    logic signed [11:0] dx, dy, col_s, row_s;
    logic               in_grid;
    logic               hit_q, sof_q;
    logic [4:0]         hit_col_q;
    logic [3:0]         hit_row_q;

    assign dx      = $signed({1'b0, pixelX}) - $signed({1'b0, topLeftX});
    assign dy      = $signed({1'b0, pixelY}) - $signed({1'b0, topLeftY});
    assign col_s   = dx >>> BLOCK_SHIFT;
    assign row_s   = dy >>> BLOCK_SHIFT;
    assign in_grid = !dx[11] && !dy[11] && (col_s < $signed(12'(COLS))) &&
                     (row_s < $signed(12'(ROWS)));

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            hit_q     <= 1'b0;
            sof_q     <= 1'b0;
            hit_col_q <= '0;
            hit_row_q <= '0;
        end else begin
            hit_q     <= hitRequest && in_grid;
            sof_q     <= startOfFrame;
            hit_col_q <= col_s[4:0];
            hit_row_q <= row_s[3:0];
        end
    end

    // Seen list and FIFO
    logic [4:0]      seen_col_q [DEPTH];
    logic [3:0]      seen_row_q [DEPTH];
    logic [CW-1:0]   seen_cnt_q, seen_cnt_eff;
    logic [8:0]      mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   count_q;
    logic            match, is_new, pop, accept, drop;
    state_t          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [4:0]      x_q;
    logic [3:0]      y_q;
    logic            overflow_q;

    // A frame start in the same cycle as a hit clears the list before the hit is looked up
    always_comb begin
        match = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((CW'(i) < seen_cnt_q) && (seen_col_q[i] == hit_col_q) &&
                (seen_row_q[i] == hit_row_q))
                match = 1'b1;
        end
        if (sof_q)
            match = 1'b0;
    end

    assign seen_cnt_eff = sof_q ? '0 : seen_cnt_q;
    assign is_new       = hit_q && !match;
    assign pop          = (state_q == S_IDLE) && (count_q != '0);
    assign accept       = is_new && (seen_cnt_eff < CW'(DEPTH)) &&
                          ((count_q < CW'(DEPTH)) || pop);
    assign drop         = is_new && !accept;

    always_ff @(posedge clk) begin
        if (accept) begin
            seen_col_q[seen_cnt_eff[PW-1:0]] <= hit_col_q;
            seen_row_q[seen_cnt_eff[PW-1:0]] <= hit_row_q;
            mem_q[wr_ptr_q]                  <= {hit_col_q, hit_row_q};
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            seen_cnt_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= drop;
            seen_cnt_q <= accept ? seen_cnt_eff + 1'b1 : seen_cnt_eff;
            if (accept)
                wr_ptr_q <= (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
            if (pop)
                rd_ptr_q <= (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
            if (accept && !pop)
                count_q <= count_q + 1'b1;
            else if (pop && !accept)
                count_q <= count_q - 1'b1;
        end
    end

    // Presentation FSM: one IDLE cycle between events gives period HOLD+GAP+1
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        case (state_q)
            S_IDLE: begin
                timer_d = '0;
                if (count_q != '0)
                    state_d = S_ASSERT;
            end
            S_ASSERT: begin
                if (timer_q == TW'(HOLD_CYCLES - 1)) begin
                    state_d = S_GAP;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_GAP: begin
                if (timer_q == TW'(GAP_CYCLES - 1)) begin
                    state_d = S_IDLE;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                timer_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q <= S_IDLE;
            timer_q <= '0;
            x_q     <= '0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            if (pop) begin
                x_q <= mem_q[rd_ptr_q][8:4];
                y_q <= mem_q[rd_ptr_q][3:0];
            end
        end
    end

    assign collision       = (state_q == S_ASSERT);
    assign brickCollisionX = x_q;
    assign brickCollisionY = y_q;
    assign overflow        = overflow_q;
    assign queueCount      = count_q;
    assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_brick_hit_queue.sv
// Directed bench for brick_hit_queue: cell mapping, dedup, frame clear, overflow,
// pulse timing and asynchronous reset.
module tb_brick_hit_queue;

    logic        clk = 1'b0;
    logic        resetN;
    logic [10:0] pixelX, pixelY, topLeftX, topLeftY;
    logic        hitRequest, startOfFrame;
    logic [4:0]  brickCollisionX;
    logic [3:0]  brickCollisionY;
    logic        collision, overflow;
    logic [2:0]  queueCount;
    logic [1:0]  dbg_state;

    int total = 0;
    int bad   = 0;

    brick_hit_queue dut (
        .clk             (clk),
        .resetN          (resetN),
        .pixelX          (pixelX),
        .pixelY          (pixelY),
        .topLeftX        (topLeftX),
        .topLeftY        (topLeftY),
        .hitRequest      (hitRequest),
        .startOfFrame    (startOfFrame),
        .brickCollisionX (brickCollisionX),
        .brickCollisionY (brickCollisionY),
        .collision       (collision),
        .overflow        (overflow),
        .queueCount      (queueCount),
        .dbg_state_o     (dbg_state)
    );

    always #5 clk = ~clk;

    // Event monitor: records each rising collision as {X,Y} and its cycle
    logic [8:0] obs_q[$];
    int         rise_cyc_q[$];
    int         cyc = 0;
    int         ovf_cnt = 0;
    logic       coll_prev = 1'b0;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (collision && !coll_prev) begin
            obs_q.push_back({brickCollisionX, brickCollisionY});
            rise_cyc_q.push_back(cyc);
        end
        coll_prev = collision;
        if (overflow)
            ovf_cnt = ovf_cnt + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++)
            step();
    endtask

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        total = total + 1;
        assert (observed === expected)
        else begin
            bad = bad + 1;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic drive_hit(input int x, input int y, input logic sof);
        pixelX       = 11'(x);
        pixelY       = 11'(y);
        hitRequest   = 1'b1;
        startOfFrame = sof;
        step();
        hitRequest   = 1'b0;
        startOfFrame = 1'b0;
    endtask

    task automatic frame_start();
        startOfFrame = 1'b1;
        step();
        startOfFrame = 1'b0;
    endtask

    task automatic clear_obs();
        obs_q.delete();
        rise_cyc_q.delete();
        ovf_cnt = 0;
    endtask

    initial begin
        resetN       = 1'b0;
        pixelX       = '0;
        pixelY       = '0;
        topLeftX     = 11'd100;
        topLeftY     = 11'd50;
        hitRequest   = 1'b0;
        startOfFrame = 1'b0;
        wait_cycles(2);

        check("rst_collision", 32'(collision), 0);
        check("rst_overflow", 32'(overflow), 0);
        check("rst_x", 32'(brickCollisionX), 0);
        check("rst_y", 32'(brickCollisionY), 0);
        check("rst_count", 32'(queueCount), 0);
        resetN = 1'b1;
        wait_cycles(2);
        clear_obs();

        // single hit at (165,83): cell (2,1), latency and pulse shape
        drive_hit(165, 83, 1'b0);
        check("t1_e0_count", 32'(queueCount), 0);
        check("t1_e0_coll", 32'(collision), 0);
        step();
        check("t1_e1_count", 32'(queueCount), 1);
        check("t1_e1_coll", 32'(collision), 0);
        step();
        check("t1_e2_coll", 32'(collision), 1);
        check("t1_e2_x", 32'(brickCollisionX), 2);
        check("t1_e2_y", 32'(brickCollisionY), 1);
        check("t1_e2_count", 32'(queueCount), 0);
        step();
        check("t1_hold2", 32'(collision), 1);
        step();
        check("t1_gap1", 32'(collision), 0);
        check("t1_gap1_x", 32'(brickCollisionX), 2);
        step();
        check("t1_gap2", 32'(collision), 0);
        step();
        check("t1_idle", 32'(collision), 0);
        check("t1_events", 32'(obs_q.size()), 1);
        wait_cycles(3);
        clear_obs();

        // 32 pixels inside cell (3,2): a single event, no overflow
        for (int k = 0; k < 32; k++) begin
            pixelX     = 11'(196 + k);
            pixelY     = 11'd114;
            hitRequest = 1'b1;
            step();
        end
        hitRequest = 1'b0;
        wait_cycles(12);
        check("t2_events", 32'(obs_q.size()), 1);
        if (obs_q.size() > 0)
            check("t2_cell", 32'(obs_q[0]), 32'({5'd3, 4'd2}));
        check("t2_ovf", 32'(ovf_cnt), 0);
        clear_obs();

        // five distinct cells in one frame: four accepted, fifth overflows
        frame_start();
        drive_hit(100, 50, 1'b0);
        drive_hit(132, 50, 1'b0);
        drive_hit(228, 146, 1'b0);
        drive_hit(612, 466, 1'b0);
        drive_hit(260, 210, 1'b0);
        step();
        check("t3_ovf_pulse", 32'(overflow), 1);
        check("t3_count", 32'(queueCount), 3);
        step();
        check("t3_ovf_one_cycle", 32'(overflow), 0);
        wait_cycles(30);
        check("t3_events", 32'(obs_q.size()), 4);
        check("t3_ovf_total", 32'(ovf_cnt), 1);
        if (obs_q.size() == 4) begin
            check("t3_ev0", 32'(obs_q[0]), 32'({5'd0, 4'd0}));
            check("t3_ev1", 32'(obs_q[1]), 32'({5'd1, 4'd0}));
            check("t3_ev2", 32'(obs_q[2]), 32'({5'd4, 4'd3}));
            check("t3_ev3", 32'(obs_q[3]), 32'({5'd16, 4'd13}));
            check("t3_period", 32'(rise_cyc_q[1] - rise_cyc_q[0]), 5);
            check("t3_period2", 32'(rise_cyc_q[3] - rise_cyc_q[2]), 5);
        end
        clear_obs();

        // frame clear: duplicate ignored, same-cycle frame start + hit accepted
        drive_hit(100, 50, 1'b0);
        wait_cycles(8);
        check("t4_dup_ignored", 32'(obs_q.size()), 0);
        drive_hit(100, 50, 1'b1);
        wait_cycles(8);
        check("t4_sof_same_cycle", 32'(obs_q.size()), 1);
        drive_hit(110, 60, 1'b0);
        wait_cycles(8);
        check("t4_dup_again", 32'(obs_q.size()), 1);
        frame_start();
        drive_hit(100, 50, 1'b0);
        wait_cycles(8);
        check("t4_next_frame", 32'(obs_q.size()), 2);
        if (obs_q.size() == 2)
            check("t4_cell", 32'(obs_q[1]), 32'({5'd0, 4'd0}));
        check("t4_ovf", 32'(ovf_cnt), 0);
        clear_obs();

        // out-of-grid hits dropped silently; last in-grid cell accepted
        frame_start();
        drive_hit(99, 50, 1'b0);
        drive_hit(644, 50, 1'b0);
        drive_hit(100, 498, 1'b0);
        wait_cycles(8);
        check("t5_dropped", 32'(obs_q.size()), 0);
        check("t5_ovf", 32'(ovf_cnt), 0);
        drive_hit(643, 497, 1'b0);
        wait_cycles(8);
        check("t5_edge_cell_events", 32'(obs_q.size()), 1);
        if (obs_q.size() == 1)
            check("t5_edge_cell", 32'(obs_q[0]), 32'({5'd16, 4'd13}));
        clear_obs();

        // reset during ASSERT with a second event queued
        frame_start();
        drive_hit(100, 50, 1'b0);
        drive_hit(132, 50, 1'b0);
        step();
        check("t6_asserted", 32'(collision), 1);
        check("t6_count_before", 32'(queueCount), 1);
        resetN = 1'b0;
        #1;
        check("t6_coll_reset", 32'(collision), 0);
        check("t6_count_reset", 32'(queueCount), 0);
        check("t6_x_reset", 32'(brickCollisionX), 0);
        wait_cycles(2);
        clear_obs();
        resetN = 1'b1;
        wait_cycles(12);
        check("t6_no_pulse", 32'(obs_q.size()), 0);
        check("t6_coll_after", 32'(collision), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
